// File: rtl/decode_scoreboard.sv
// Issue controller around the decode stage: per-register in-flight write scoreboard,
// RAW/saturation stall, and the decode->execute issue register with flush.
`timescale 1ns/1ps
module decode_scoreboard #(
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_valid,
    output logic              f_ready,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              use_ra1,
    input  logic              use_ra2,
    input  logic [ADDR_W-1:0] dst,
    input  logic              wen,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [ADDR_W-1:0] d_dst,
    output logic              d_wen,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dst,
    input  logic              flush,
    output logic [31:0]       stall_cnt,
    output logic              sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic              d_valid_q, d_valid_d;
    logic [ADDR_W-1:0] d_dst_q, d_dst_d;
    logic              d_wen_q, d_wen_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;
    logic              sb_err_q, sb_err_d;

    logic wr, haz, space, accept, underflow;

    // Hazards look only at registered counters, so a same-cycle retire releases next cycle.
    always_comb begin
        wr  = wen && (dst != '0);
        haz = (use_ra1 && (ra1 != '0) && (cnt_q[ra1] != '0)) ||
              (use_ra2 && (ra2 != '0) && (cnt_q[ra2] != '0)) ||
              (wr && (cnt_q[dst] == CNT_MAX));
    end

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // valid never depends on ready, and the issue register frees on consume or flush.
    assign space   = !d_valid_q || d_ready;
    assign f_ready = reset && space && !haz && !flush;
    assign accept  = f_valid && f_ready;

    // Net delta per register; a negative result clamps to zero and raises the sticky error.
    always_comb begin
        logic              inc;
        logic              dec_wb;
        logic              dec_fl;
        logic [CNT_W+1:0]  nxt;
        inc       = 1'b0;
        dec_wb    = 1'b0;
        dec_fl    = 1'b0;
        nxt       = '0;
        underflow = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            inc    = accept && wr && (dst == ADDR_W'(i));
            dec_wb = wb_valid && (wb_dst == ADDR_W'(i));
            dec_fl = flush && d_valid_q && d_wen_q && (d_dst_q == ADDR_W'(i));
            nxt    = {2'b00, cnt_q[i]} + {{(CNT_W+1){1'b0}}, inc}
                   - {{(CNT_W+1){1'b0}}, dec_wb} - {{(CNT_W+1){1'b0}}, dec_fl};
            if (i == 0) begin
                cnt_d[i] = '0;
            end else if (nxt[CNT_W+1]) begin
                cnt_d[i]  = '0;
                underflow = 1'b1;
            end else if (nxt[CNT_W]) begin
                cnt_d[i] = CNT_MAX;
            end else begin
                cnt_d[i] = nxt[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        d_valid_d = d_valid_q;
        d_dst_d   = d_dst_q;
        d_wen_d   = d_wen_q;
        if (flush) begin
            d_valid_d = 1'b0;
        end else if (accept) begin
            d_valid_d = 1'b1;
            d_dst_d   = dst;
            d_wen_d   = wr;
        end else if (d_ready && d_valid_q) begin
            d_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (f_valid && !f_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        sb_err_d = sb_err_q || underflow;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            d_valid_q   <= 1'b0;
            d_dst_q     <= '0;
            d_wen_q     <= 1'b0;
            stall_cnt_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            d_valid_q   <= d_valid_d;
            d_dst_q     <= d_dst_d;
            d_wen_q     <= d_wen_d;
            stall_cnt_q <= stall_cnt_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign d_valid   = d_valid_q;
    assign d_dst     = d_dst_q;
    assign d_wen     = d_wen_q;
    assign stall_cnt = stall_cnt_q;
    assign sb_err    = sb_err_q;

endmodule
